// File: rtl/fifo_wptr_full_if.sv
// rtl/fifo_wptr_full_if.sv - write-side pointer/flag bundle for the async FIFO
//
// Purpose: groups the producer request, synchronized read pointer, memory write
//          port and status flags of the FIFO write-side pointer block.
// Ports (signals):
//    winc          producer write request
//    wovf_clr      clear for the sticky overflow flag
//    rptr_sync     Gray read pointer, already synchronized into the write domain
//    wen, waddr    memory write enable / address
//    wptr          registered Gray write pointer for the read-side synchronizer
//    wfull, walmost_full, wlevel, wovf   status flags
// Modports: master = producer/testbench side, slave = fifo_wptr_full.

interface fifo_wptr_full_if #(
   parameter int ADDR_WIDTH = 6
);
   logic                  winc;
   logic                  wovf_clr;
   logic [ADDR_WIDTH:0]   rptr_sync;
   logic                  wen;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [ADDR_WIDTH:0]   wptr;
   logic                  wfull;
   logic                  walmost_full;
   logic [ADDR_WIDTH:0]   wlevel;
   logic                  wovf;

   modport master (
      output winc, wovf_clr, rptr_sync,
      input  wen, waddr, wptr, wfull, walmost_full, wlevel, wovf
   );

   modport slave (
      input  winc, wovf_clr, rptr_sync,
      output wen, waddr, wptr, wfull, walmost_full, wlevel, wovf
   );
endinterface

// File: rtl/fifo_wptr_full.sv
// rtl/fifo_wptr_full.sv - async FIFO write-side pointer, full/level/overflow flags
//
// Purpose: keeps the binary write pointer, drives the memory write port,
//          publishes a registered Gray write pointer and derives full,
//          almost-full, fill level and sticky overflow from the synchronized
//          Gray read pointer.
// Ports:
//    clk   write-domain clock
//    rst   synchronous active-high reset
//    bus   fifo_wptr_full_if.slave (winc, wovf_clr, rptr_sync in;
//          wen, waddr, wptr, wfull, walmost_full, wlevel, wovf out)

module fifo_wptr_full #(
   parameter int ADDR_WIDTH   = 6,
   parameter int AFULL_THRESH = 56
) (
   input  logic            clk,
   input  logic            rst,
   fifo_wptr_full_if.slave bus
);
   localparam int AW = ADDR_WIDTH;
   localparam logic [AW:0] AFULL_T = (AW+1)'(AFULL_THRESH);

   logic [AW:0] wbin;
   logic [AW:0] wbin_next;
   logic [AW:0] wgray_next;
   logic [AW:0] rbin;
   logic [AW:0] wdiff;
   logic [AW:0] wptr_q;
   logic [AW:0] wlevel_q;
   logic        wfull_q;
   logic        wafull_q;
   logic        wovf_q;
   logic        wen_i;
   logic        wfull_next;

   // A write while full is dropped; reset also blocks the memory write.
   assign wen_i      = bus.winc & ~wfull_q & ~rst;
   assign wbin_next  = wbin + {{AW{1'b0}}, wen_i};
   assign wgray_next = (wbin_next >> 1) ^ wbin_next;

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      rbin = '0;
      for (int i = 0; i <= AW; i++) begin
         rbin[i] = ^(bus.rptr_sync >> i);
      end
   end

   // Modular difference is always 0..2**AW because the writer never laps the reader.
   assign wdiff = wbin_next - rbin;

   // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
   assign wfull_next = (wgray_next == {~bus.rptr_sync[AW:AW-1], bus.rptr_sync[AW-2:0]});

   always_ff @(posedge clk) begin
      if (rst) begin
         wbin     <= '0;
         wptr_q   <= '0;
         wlevel_q <= '0;
         wfull_q  <= 1'b0;
         wafull_q <= 1'b0;
         wovf_q   <= 1'b0;
      end else begin
         wbin     <= wbin_next;
         wptr_q   <= wgray_next;
         wlevel_q <= wdiff;
         wfull_q  <= wfull_next;
         wafull_q <= (wdiff >= AFULL_T);
         // A new overflow takes priority over a clear in the same cycle.
         wovf_q   <= (bus.winc & wfull_q) | (wovf_q & ~bus.wovf_clr);
      end
   end

   assign bus.wen          = wen_i;
   assign bus.waddr        = wbin[AW-1:0];
   assign bus.wptr         = wptr_q;
   assign bus.wfull        = wfull_q;
   assign bus.walmost_full = wafull_q;
   assign bus.wlevel       = wlevel_q;
   assign bus.wovf         = wovf_q;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb/tb_fifo_wptr_full.sv - scoreboard bench for fifo_wptr_full

module tb_fifo_wptr_full;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   fifo_wptr_full_if #(.ADDR_WIDTH(6)) bus ();

   fifo_wptr_full #(.ADDR_WIDTH(6), .AFULL_THRESH(56)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic       wen;
      logic [5:0] waddr;
      logic [6:0] wptr;
      logic       wfull;
      logic       wafull;
      logic [6:0] wlevel;
      logic       wovf;
      logic       after_rst;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference state: unbounded write/read counts instead of pointers.
   int   m_wc  = 0;
   int   m_rc  = 0;
   logic m_full = 1'b0;
   logic m_af   = 1'b0;
   logic m_ovf  = 1'b0;
   logic m_after_rst = 1'b1;

   function automatic logic [6:0] gray7(input int n);
      logic [6:0] b;
      b = 7'(n % 128);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock of stimulus: apply inputs, queue the expectation, advance the model.
   task automatic step(input logic r, input logic wi, input logic clr, input int rc, input bit push);
      exp_t e;
      logic wen_m;
      int   lvl;
      @(posedge clk);
      #1;
      rst           = r;
      bus.winc      = wi;
      bus.wovf_clr  = clr;
      bus.rptr_sync = gray7(rc);
      wen_m = ~r & wi & ~m_full;
      e.wen       = wen_m;
      e.waddr     = 6'(m_wc % 64);
      e.wptr      = gray7(m_wc);
      e.wfull     = m_full;
      e.wafull    = m_af;
      e.wlevel    = 7'(m_wc - m_rc);
      e.wovf      = m_ovf;
      e.after_rst = m_after_rst;
      if (push) q.push_back(e);
      if (r) begin
         m_wc = 0; m_rc = 0; m_full = 0; m_af = 0; m_ovf = 0; m_after_rst = 1;
      end else begin
         m_ovf = (wi & m_full) ? 1'b1 : (clr ? 1'b0 : m_ovf);
         m_wc  = m_wc + (wen_m ? 1 : 0);
         m_rc  = rc;
         lvl   = m_wc - m_rc;
         m_full = (lvl == 64);
         m_af   = (lvl >= 56);
         m_after_rst = 0;
      end
   endtask

   // Monitor: registered outputs are stable at the falling edge, inputs already applied.
   logic [6:0] prev_wptr;
   bit         have_prev = 0;
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("wen",          7'(bus.wen),          7'(e.wen));
            chk("waddr",        7'(bus.waddr),        7'(e.waddr));
            chk("wptr",         bus.wptr,             e.wptr);
            chk("wfull",        7'(bus.wfull),        7'(e.wfull));
            chk("walmost_full", 7'(bus.walmost_full), 7'(e.wafull));
            chk("wlevel",       bus.wlevel,           e.wlevel);
            chk("wovf",         7'(bus.wovf),         7'(e.wovf));
            if (have_prev && !e.after_rst)
               chk("wptr_onebit", 7'($countones(prev_wptr ^ bus.wptr) <= 1), 7'd1);
            prev_wptr = bus.wptr;
            have_prev = 1;
         end
      end
   end

   initial begin
      int base;
      rst           = 1'b1;
      bus.winc      = 1'b1;
      bus.wovf_clr  = 1'b0;
      bus.rptr_sync = '0;

      // 1: reset held two cycles with winc high
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 1);

      // 2: fill 64 entries with the reader idle
      for (int i = 0; i < 64; i++) step(0, 1, 0, 0, 1);

      // 3: overflow while full, clear, then clear racing a new overflow
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1);
      step(0, 0, 1, 0, 1);
      step(0, 1, 1, 0, 1);
      step(0, 0, 0, 0, 1);

      // 4: reader advances to 8 then 9
      step(0, 0, 0, 8, 1);
      step(0, 0, 0, 9, 1);
      step(0, 0, 0, 9, 1);

      // 5: drain, then reader tracks the writer across pointer wrap
      step(0, 0, 0, m_wc, 1);
      for (int i = 0; i < 300; i++) begin
         step(0, 1, 0, m_wc, 1);
         step(0, 0, 0, m_wc, 1);
      end

      // 6: build level 30, reset mid-burst, resume from address 0
      base = m_wc;
      step(0, 0, 0, base, 1);
      for (int i = 0; i < 30; i++) step(0, 1, 0, base, 1);
      step(1, 1, 0, 0, 1);
      for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1);
      step(0, 0, 0, 0, 1);

      // Let the monitor drain the queue, bounded.
      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
      @(posedge clk);
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
